// File: rtl/spi_adc_sampler.sv
// spi_adc_sampler: periodic SPI reader for an MCP3008-style ADC. Each reading is
// re-centred to a signed value and reduced to DATA_RESOLUTION bits, then
// presented on data_out with a one-cycle data_valid_out strobe.
// Optional build macro: SPI_ADC_SAMPLER_AVG_EN adds a 4-sample moving average
// on data_out (same latency). Without it, data_out is the converted reading.
module spi_adc_sampler #(
  parameter int unsigned SAMPLE_PERIOD   = 74250,
  parameter int unsigned SCLK_DIV        = 32,
  parameter int unsigned ADC_BITS        = 10,
  parameter int unsigned DATA_RESOLUTION = 8,
  parameter int unsigned CHANNEL         = 0
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              enable_in,
  input  logic                              adc_miso_in,
  output logic                              adc_cs_n_out,
  output logic                              adc_sclk_out,
  output logic                              adc_mosi_out,
  output logic                              busy_out,
  output logic                              data_valid_out,
  output logic signed [DATA_RESOLUTION-1:0] data_out
);

  localparam int unsigned TIMER_W     = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DIV_W       = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned PERIOD_W    = 5;
  // Frame is 17 SCLK periods, indexed 0..16 internally.
  localparam int unsigned LAST_PERIOD = 16;
  // Rising edge 8 (0-based period 7) carries the first result bit.
  localparam int unsigned FIRST_DATA_PERIOD = 7;
  localparam int unsigned SHIFT       = ADC_BITS - DATA_RESOLUTION;
  localparam logic [2:0]  CH_SEL      = 3'(CHANNEL);

  // Parameter sanity checks at elaboration.
  if (SAMPLE_PERIOD < 34 * SCLK_DIV + 4) begin : g_bad_period
    $error("spi_adc_sampler: SAMPLE_PERIOD must be at least 34*SCLK_DIV+4");
  end
  if (DATA_RESOLUTION > ADC_BITS) begin : g_bad_resolution
    $error("spi_adc_sampler: DATA_RESOLUTION must not exceed ADC_BITS");
  end
  if (CHANNEL > 7) begin : g_bad_channel
    $error("spi_adc_sampler: CHANNEL must be 0..7");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                              state;
  logic [TIMER_W-1:0]                  timer;
  logic                                tick;
  logic [DIV_W-1:0]                    div_cnt;
  logic [PERIOD_W-1:0]                 period;
  logic [ADC_BITS-1:0]                 raw;
  logic signed [ADC_BITS-1:0]          centered;
  logic signed [DATA_RESOLUTION-1:0]   conv;
  logic signed [DATA_RESOLUTION-1:0]   sample;

  // Command bit driven on MOSI during 0-based SCLK period idx:
  // start, single-ended, then the channel number MSB first.
  function automatic logic cmd_bit(input logic [PERIOD_W-1:0] idx);
    logic b;
    b = 1'b0;
    case (idx)
      5'd0:    b = 1'b1;
      5'd1:    b = 1'b1;
      5'd2:    b = CH_SEL[2];
      5'd3:    b = CH_SEL[1];
      5'd4:    b = CH_SEL[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Sample-rate tick: fires on the last count of each period while enabled.
  assign tick = enable_in && (timer == TIMER_W'(SAMPLE_PERIOD - 1));

  // Free-running period timer, cleared and held while disabled.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      timer <= '0;
    end else if (!enable_in || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

  // Offset-binary to two's complement, then floor-shift down to output width.
  assign centered = $signed({~raw[ADC_BITS-1], raw[ADC_BITS-2:0]});
  assign conv     = DATA_RESOLUTION'(centered >>> SHIFT);

`ifdef SPI_ADC_SAMPLER_AVG_EN
  localparam int unsigned SUM_W = DATA_RESOLUTION + 2;

  logic signed [DATA_RESOLUTION-1:0] hist0;
  logic signed [DATA_RESOLUTION-1:0] hist1;
  logic signed [DATA_RESOLUTION-1:0] hist2;
  logic signed [SUM_W-1:0]           sum;

  // Sum of the new reading and the three previous delivered readings.
  always_comb begin
    sum    = SUM_W'(conv) + SUM_W'(hist0) + SUM_W'(hist1) + SUM_W'(hist2);
    sample = DATA_RESOLUTION'(sum >>> 2);
  end

  // History shifts only when a sample is delivered.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hist0 <= '0;
      hist1 <= '0;
      hist2 <= '0;
    end else if (state == DONE) begin
      hist0 <= conv;
      hist1 <= hist0;
      hist2 <= hist1;
    end
  end
`else
  assign sample = conv;
`endif

  // Transaction FSM with registered SPI pins, busy and sample outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      div_cnt        <= '0;
      period         <= '0;
      raw            <= '0;
      adc_cs_n_out   <= 1'b1;
      adc_sclk_out   <= 1'b0;
      adc_mosi_out   <= 1'b0;
      busy_out       <= 1'b0;
      data_valid_out <= 1'b0;
      data_out       <= '0;
    end else begin
      data_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            state        <= XFER;
            div_cnt      <= '0;
            period       <= '0;
            adc_cs_n_out <= 1'b0;
            adc_sclk_out <= 1'b0;
            adc_mosi_out <= cmd_bit('0);
            busy_out     <= 1'b1;
          end
        end
        XFER: begin
          if (div_cnt == DIV_W'(SCLK_DIV - 1)) begin
            div_cnt <= '0;
            if (!adc_sclk_out) begin
              // Rising SCLK: capture MISO once the result bits begin.
              adc_sclk_out <= 1'b1;
              if (period >= PERIOD_W'(FIRST_DATA_PERIOD)) begin
                raw <= {raw[ADC_BITS-2:0], adc_miso_in};
              end
            end else begin
              // Falling SCLK: either end the frame or advance to the next period.
              adc_sclk_out <= 1'b0;
              if (period == PERIOD_W'(LAST_PERIOD)) begin
                state        <= DONE;
                adc_cs_n_out <= 1'b1;
                adc_mosi_out <= 1'b0;
              end else begin
                period       <= period + PERIOD_W'(1);
                adc_mosi_out <= cmd_bit(period + PERIOD_W'(1));
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        DONE: begin
          state          <= IDLE;
          busy_out       <= 1'b0;
          data_valid_out <= 1'b1;
          data_out       <= sample;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_sampler.sv
// Testbench for spi_adc_sampler: an ADC model answers each frame with a directed
// or random reading; a behavioural model predicts every delivered sample.
`timescale 1ns/1ps
module tb_spi_adc_sampler;

  localparam int P          = 100;
  localparam int D          = 2;
  localparam int AB         = 10;
  localparam int DR         = 8;
  localparam int CH         = 5;
  localparam int FRAME_LEN  = 34 * D;
  localparam int STROBE_LAT = 34 * D + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic miso = 1'b0;
  logic cs_n, sclk, mosi, busy, valid;
  logic signed [DR-1:0] data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Monitor / ADC-model state
  int raw_q[$];
  int conv_hist[$] = '{0, 0, 0};
  int fall_q[$];
  int obs_q[$];
  int exp_fixed[$];
  int n_valid = 0;
  int edge_cnt = 0;
  int fall_cyc = 0;
  int cur_raw = 0;
  bit in_frame = 0;
  bit pending = 0;
  logic prev_cs = 1'b1;
  logic prev_sclk = 1'b0;
  logic prev_valid = 1'b0;

  spi_adc_sampler #(
    .SAMPLE_PERIOD(P),
    .SCLK_DIV(D),
    .ADC_BITS(AB),
    .DATA_RESOLUTION(DR),
    .CHANNEL(CH)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .enable_in(enable),
    .adc_miso_in(miso),
    .adc_cs_n_out(cs_n),
    .adc_sclk_out(sclk),
    .adc_mosi_out(mosi),
    .busy_out(busy),
    .data_valid_out(valid),
    .data_out(data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_div(input int v, input int d);
    int q;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  // Expected data_out for a delivered reading; advances the averaging history.
  function automatic int model_sample(input int raw);
    int c;
    int s;
    c = floor_div(raw - (1 << (AB - 1)), 1 << (AB - DR));
    s = c;
`ifdef SPI_ADC_SAMPLER_AVG_EN
    foreach (conv_hist[i]) s += conv_hist[i];
    conv_hist.push_front(c);
    void'(conv_hist.pop_back());
    s = floor_div(s, 4);
`endif
    return s;
  endfunction

  // Command bit the ADC should see on rising edge n (1-based).
  function automatic int exp_mosi(input int n);
    case (n)
      1, 2:    return 1;
      3:       return (CH >> 2) & 1;
      4:       return (CH >> 1) & 1;
      5:       return CH & 1;
      default: return 0;
    endcase
  endfunction

  // ADC output for rising edge n: result MSB first on edges 8..17, junk earlier.
  function automatic logic adc_bit(input int raw, input int n);
    if (n >= 8 && n <= 17) return 1'((raw >> (17 - n)) & 1);
    return 1'($urandom_range(0, 1));
  endfunction

  // Bus monitor and ADC model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame   = 0;
      pending    = 0;
      prev_cs    = 1'b1;
      prev_sclk  = 1'b0;
      prev_valid = 1'b0;
      conv_hist  = '{0, 0, 0};
    end else begin
      if (prev_valid) check("valid_pulse", int'(valid), 0);
      if (valid) begin
        check("valid_expected", int'(pending), 1);
        if (pending) begin
          check("strobe_lat", cyc - fall_cyc, STROBE_LAT);
          check("data", int'(data), model_sample(cur_raw));
          check("busy_after", int'(busy), 0);
          obs_q.push_back(int'(data));
          n_valid++;
          pending = 0;
        end
      end
      if (prev_cs && !cs_n) begin
        check("busy_xfer", int'(busy), 1);
        in_frame = 1;
        edge_cnt = 0;
        fall_cyc = cyc;
        fall_q.push_back(cyc);
        if (raw_q.size() > 0) cur_raw = raw_q.pop_front();
        else cur_raw = int'($urandom_range(0, (1 << AB) - 1));
        miso = adc_bit(cur_raw, 1);
      end else if (!prev_cs && cs_n && in_frame) begin
        check("cs_low_len", cyc - fall_cyc, FRAME_LEN);
        check("sclk_edges", edge_cnt, 17);
        check("sclk_idle", int'(sclk), 0);
        check("busy_done", int'(busy), 1);
        in_frame = 0;
        pending  = 1;
      end else if (in_frame) begin
        if (!prev_sclk && sclk) begin
          edge_cnt++;
          check($sformatf("mosi_e%0d", edge_cnt), int'(mosi), exp_mosi(edge_cnt));
        end else if (prev_sclk && !sclk) begin
          miso = adc_bit(cur_raw, edge_cnt + 1);
        end
      end
      prev_cs    = cs_n;
      prev_sclk  = sclk;
      prev_valid = valid;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_falls(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (fall_q.size() < target && n < budget) begin
      step();
      n++;
    end
    if (fall_q.size() < target) check(tag, fall_q.size(), target);
  endtask

  task automatic wait_valids(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (n_valid < target && n < budget) begin
      step();
      n++;
    end
    if (n_valid < target) check(tag, n_valid, target);
  endtask

  initial begin
    int rel;
    int base;
    int nv;
    int n;

`ifdef SPI_ADC_SAMPLER_AVG_EN
    raw_q     = '{'h3FF, 'h3FF, 'h3FF, 'h3FF, 'h000};
    exp_fixed = '{31, 63, 95, 127, 63};
`else
    raw_q     = '{'h3FF, 'h000, 'h200, 'h1FF};
    exp_fixed = '{127, -128, 0, -1};
`endif

    // Reset values
    repeat (3) step();
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_sclk", int'(sclk), 0);
    check("rst_mosi", int'(mosi), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_data", int'(data), 0);

    // Release with enable high: first frame one full period later
    rst_n  = 1'b1;
    enable = 1'b1;
    rel    = cyc;
    wait_falls(1, P + 10, "first_fall_timeout");
    if (fall_q.size() > 0) check("first_tick", fall_q[0] - rel, P);

    // Directed boundary readings followed by random ones
    wait_valids(15, 15 * P + 200, "run_timeout");
    if (fall_q.size() > 2) begin
      check("period_0_1", fall_q[1] - fall_q[0], P);
      check("period_1_2", fall_q[2] - fall_q[1], P);
    end
    for (int i = 0; i < exp_fixed.size(); i++) begin
      if (i < obs_q.size()) check($sformatf("fixed_%0d", i), obs_q[i], exp_fixed[i]);
    end

    // Disable for 500 cycles: no CS activity and no strobe
    enable = 1'b0;
    base   = fall_q.size();
    nv     = n_valid;
    repeat (500) step();
    check("dis_no_cs", fall_q.size(), base);
    check("dis_no_strobe", n_valid, nv);
    check("dis_cs_high", int'(cs_n), 1);
    enable = 1'b1;
    rel    = cyc;
    wait_falls(base + 1, P + 10, "reenable_timeout");
    if (fall_q.size() > base) check("reenable_fall", fall_q[base] - rel, P);
    wait_valids(nv + 1, 2 * P, "reenable_strobe_timeout");

    // Reset pulse mid-frame while SCLK is high
    base = fall_q.size();
    wait_falls(base + 1, P + 10, "prereset_timeout");
    n = 0;
    while (!sclk && n < 10) begin
      step();
      n++;
    end
    check("mid_sclk_high", int'(sclk), 1);
    nv    = n_valid;
    rst_n = 1'b0;
    #1;
    check("async_cs_n", int'(cs_n), 1);
    check("async_sclk", int'(sclk), 0);
    check("async_busy", int'(busy), 0);
    repeat (3) step();
    rst_n = 1'b1;
    rel   = cyc;
    base  = fall_q.size();
    wait_falls(base + 1, P + 10, "postreset_timeout");
    if (fall_q.size() > base) check("postreset_fall", fall_q[base] - rel, P);
    check("reset_no_strobe", n_valid, nv);
    wait_valids(nv + 1, P, "postreset_strobe_timeout");

    // Drop enable during a frame: sample still delivered, then silence
    base = fall_q.size();
    wait_falls(base + 1, P + 10, "late_fall_timeout");
    repeat (10) step();
    enable = 1'b0;
    nv     = n_valid;
    wait_valids(nv + 1, P, "late_strobe_timeout");
    check("late_disable_strobe", n_valid, nv + 1);
    base = fall_q.size();
    repeat (300) step();
    check("late_disable_no_cs", fall_q.size(), base);
    check("late_disable_no_more", n_valid, nv + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
